// File: rtl/byte_data_memory_if.sv
// Request/response bundle for the byte memory: level-held read/write request
// with a combinational busywait back-pressure and a registered response.
interface byte_data_memory_if;
  // Handshake: the requester holds exactly one of read/write (plus address and
  // writedata) until it samples busywait low; that low cycle is the completion
  // cycle, where readdata and addr_err are valid.
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic        addr_err;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait, addr_err
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait, addr_err
  );
endinterface

// File: rtl/byte_data_memory.sv
// Byte-wide memory with a fixed multi-cycle access latency, modelled as an
// IDLE -> ACCESS -> DONE sequencer with full 32-bit range checking.
module byte_data_memory #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic                clock,
  input  logic                reset,
  byte_data_memory_if.slave   bus,
  output logic [1:0]          dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic [7:0]  readdata_q, readdata_d;
  logic        addr_err_q, addr_err_d;
  logic        mem_we;
  logic        valid_req;
  logic        in_range;

  logic [7:0]  mem_q [DEPTH];

  // Both read and write high is not a request at all.
  assign valid_req = bus.read ^ bus.write;
  assign in_range  = (addr_q < 32'(DEPTH));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    readdata_d = readdata_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_req) begin
          addr_d     = bus.address;
          wdata_d    = bus.writedata;
          is_write_d = bus.write;
          cnt_d      = 4'(LATENCY - 1);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Out-of-range writes are dropped, reads return zero.
          if (is_write_q) begin
            mem_we = in_range;
          end else begin
            readdata_d = in_range ? mem_q[addr_q[AW-1:0]] : 8'h00;
          end
          addr_err_d = ~in_range;
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 8'h00;
      is_write_q <= 1'b0;
      readdata_q <= 8'h00;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      readdata_q <= readdata_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array survives reset; a write aborted by reset is never committed.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[addr_q[AW-1:0]] <= wdata_q;
    end
  end

  // While reset is high the sequencer is treated as IDLE.
  assign bus.busywait = reset ? valid_req
                              : ((state_q == ACCESS) || ((state_q == IDLE) && valid_req));
  assign bus.readdata = readdata_q;
  assign bus.addr_err = addr_err_q;
  assign dbg_state    = state_q;

endmodule
